// File: rtl/fetch.sv
// Instruction fetch stage: program counter, memory request/valid handshake and a
// one-cycle issue strobe to the decoder. Define FETCH_HALT_EN to make opcode 111 halt.
module fetch #(
  parameter int ADDRESS_BITS = 5,
  parameter int INSTR_BITS   = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               run,
  input  logic                               stall,
  output logic [ADDRESS_BITS-1:0]            o_mem_addr,
  output logic                               o_mem_rd,
  input  logic                               mem_valid,
  input  logic [INSTR_BITS+ADDRESS_BITS-1:0] mem_data,
  output logic [INSTR_BITS+ADDRESS_BITS-1:0] o_value,
  output logic                               o_enable,
  output logic [ADDRESS_BITS-1:0]            o_pc,
  output logic                               o_halted,
  output logic [2:0]                         dbg_state
);

  localparam int VALUE_BITS = INSTR_BITS + ADDRESS_BITS;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0]              state;
  logic [INSTR_BITS-1:0]   opcode;
  logic [ADDRESS_BITS-1:0] pc_inc;
  logic                    is_nop;
  logic                    is_halt;
  logic                    issuable;

  assign opcode = o_value[VALUE_BITS-1 -: INSTR_BITS];
  assign pc_inc = o_pc + ADDRESS_BITS'(1);
  assign is_nop = (opcode == '0);
`ifdef FETCH_HALT_EN
  assign is_halt = (opcode == '1);
`else
  assign is_halt = 1'b0;
`endif
  assign issuable  = ~is_nop & ~is_halt;
  assign o_enable  = (state == S_ISSUE) & ~stall & issuable;
  assign dbg_state = state;

  // Handshake: o_mem_rd is high for exactly the REQ cycle with o_mem_addr valid;
  // mem_data is taken on the first WAIT cycle that sees mem_valid, never in REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      o_value    <= '0;
      o_mem_rd   <= 1'b0;
      o_mem_addr <= '0;
      o_pc       <= '0;
      o_halted   <= 1'b0;
    end else begin
      o_mem_rd <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state      <= S_REQ;
            o_mem_rd   <= 1'b1;
            o_mem_addr <= o_pc;
          end
        end
        S_REQ: state <= S_WAIT;
        S_WAIT: begin
          if (mem_valid) begin
            o_value <= mem_data;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (is_halt) begin
            o_halted <= 1'b1;
            state    <= S_HALT;
          end else if (is_nop || !stall) begin
            // NOPs retire without a strobe and without honouring stall.
            o_pc <= pc_inc;
            if (run) begin
              state      <= S_REQ;
              o_mem_rd   <= 1'b1;
              o_mem_addr <= pc_inc;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
